gather: RTL

GATHER -- requirements
Module: gather

---
 rtl/gather_pkg.sv | 8 +
 rtl/gather_lane.sv | 38 +++
 rtl/gather.sv | 49 ++++
 3 files changed

// File: rtl/gather_pkg.sv
// Defaults shared by the gather block and its per-lane slice.
package gather_pkg;

  // Default lane word width and lane count.
  localparam int GATHER_W_DEF = 8;
  localparam int GATHER_N_DEF = 2;

endpackage

// File: rtl/gather_lane.sv
// One gather lane: a W-bit holding register, its valid flag and the ready logic.
// A held word is released only by the joint output transfer (xfer). A new word
// may be accepted in that same cycle, so one word per cycle is sustained.
module gather_lane
  import gather_pkg::*;
#(
  parameter int W = GATHER_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stb,
  input  logic [W-1:0] dat,
  input  logic         xfer,
  output logic         rdy,
  output logic         vld,
  output logic [W-1:0] hold
);

  logic take;

  // Slot is free when empty or when it is being drained this cycle.
  assign rdy  = ~vld | xfer;
  assign take = stb & rdy;

  // Capture on lane transfer, drop on output transfer, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld  <= 1'b0;
      hold <= '0;
    end else if (take) begin
      vld  <= 1'b1;
      hold <= dat;
    end else if (xfer) begin
      vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/gather.sv
// Gather: joins N independent W-bit lanes into one N*W master word.
// m_stb rises once every lane holds a word. m_dat is driven straight from the
// lane registers. The m_rdy -> s_rdy path is combinational so all lanes can
// refill in the same cycle the joined word leaves.
module gather
  import gather_pkg::*;
#(
  parameter int W = GATHER_W_DEF,
  parameter int N = GATHER_N_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   s_stb,
  input  logic [N*W-1:0] s_dat,
  output logic [N-1:0]   s_rdy,
  output logic           m_stb,
  output logic [N*W-1:0] m_dat,
  input  logic           m_rdy
);

  logic [N-1:0][W-1:0] lane_dat;
  logic [N-1:0][W-1:0] lane_hold;
  logic [N-1:0]        lane_vld;
  logic                xfer;

  assign lane_dat = s_dat;

  // Joined word is complete only when every lane has its word.
  assign m_stb = &lane_vld;
  assign xfer  = m_stb & m_rdy;
  assign m_dat = lane_hold;

  genvar i;
  generate
    for (i = 0; i < N; i++) begin : g_lane
      gather_lane #(.W(W)) u_lane (
        .clk  (clk),
        .rst  (rst),
        .stb  (s_stb[i]),
        .dat  (lane_dat[i]),
        .xfer (xfer),
        .rdy  (s_rdy[i]),
        .vld  (lane_vld[i]),
        .hold (lane_hold[i])
      );
    end
  endgenerate

endmodule
